note_voice: RTL and testbench



---
 rtl/note_voice.sv | 125 ++++++++++++
 tb/tb_note_voice.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_voice.sv
// note_voice: note/duration driven oscillator sample source for the voice path.
// Emits one sample every SAMPLE_DIV enabled cycles with a one-cycle out_ready
// strobe, and times the note in beats of BEAT_SAMPLES samples, then pulses note_done.
// Optional build macro: NOTE_VOICE_TRIANGLE_EN selects a triangle wave in place
// of the default square wave.
module note_voice #(
    parameter int SAMPLE_DIV   = 10,
    parameter int BEAT_SAMPLES = 48,
    parameter int PHASE_W      = 22,
    parameter int INC_SHIFT    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play_enable,
    input  logic               load_new_note,
    input  logic [5:0]         note_to_load,
    input  logic [5:0]         duration_to_load,
    output logic signed [15:0] sample_out,
    output logic               out_ready,
    output logic               note_done,
    output logic               busy
);

    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int BEAT_W = $clog2(BEAT_SAMPLES + 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t              state;
    logic [5:0]          note;
    logic [5:0]          beats_left;
    logic [DIV_W-1:0]    div_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W-1:0]  inc;
    logic signed [15:0]  wave;
    logic                strobe;

    // Increment wraps naturally with the accumulator width.
    assign inc = PHASE_W'(note) << INC_SHIFT;

    // The strobe is registered on the edge where div_cnt steps onto its last
    // value, so out_ready is visible exactly SAMPLE_DIV-1 edges after the load.
    assign strobe = play_enable && (div_cnt == DIV_W'(SAMPLE_DIV - 2));

`ifdef NOTE_VOICE_TRIANGLE_EN
    logic [15:0] tri_p;
    logic [15:0] tri_u;

    // Triangle: fold the upper phase bits on the MSB, then offset to signed.
    always_comb begin
        tri_p = phase[PHASE_W-2 -: 16];
        tri_u = phase[PHASE_W-1] ? ~tri_p : tri_p;
        wave  = (note == 6'd0) ? 16'sd0 : $signed({~tri_u[15], tri_u[14:0]});
    end
`else
    // Square: sign taken from the phase MSB; a rest note is silent.
    always_comb begin
        if (note == 6'd0)
            wave = 16'sd0;
        else if (phase[PHASE_W-1])
            wave = -16'sd32767;
        else
            wave = 16'sd32767;
    end
`endif

    // Control FSM, sample/beat counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            note       <= '0;
            beats_left <= '0;
            div_cnt    <= '0;
            beat_cnt   <= '0;
            phase      <= '0;
            sample_out <= '0;
            out_ready  <= 1'b0;
            note_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out_ready <= 1'b0;
            note_done <= 1'b0;
            if (load_new_note) begin
                // Load (or retrigger): old note is dropped without note_done.
                note       <= note_to_load;
                beats_left <= duration_to_load;
                phase      <= '0;
                div_cnt    <= '0;
                beat_cnt   <= '0;
                state      <= PLAY;
                busy       <= 1'b1;
            end else if (state == PLAY) begin
                if (beats_left == 6'd0) begin
                    // Zero-length note: finish immediately, no samples.
                    note_done  <= 1'b1;
                    state      <= IDLE;
                    busy       <= 1'b0;
                    sample_out <= '0;
                end else if (play_enable) begin
                    div_cnt <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + 1'b1;
                    if (strobe) begin
                        sample_out <= wave;
                        out_ready  <= 1'b1;
                        phase      <= phase + inc;
                        if (beat_cnt == BEAT_W'(BEAT_SAMPLES - 1)) begin
                            beat_cnt   <= '0;
                            beats_left <= beats_left - 1'b1;
                            if (beats_left == 6'd1) begin
                                note_done <= 1'b1;
                                state     <= IDLE;
                                busy      <= 1'b0;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
            end else begin
                sample_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_note_voice.sv
// Directed bench for note_voice at default parameters. Expected values are
// hand-derived: increment for note N is N*1024, square sign flips once the
// phase reaches 2^21 (note 57: from strobe 37 on).
module tb_note_voice;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               play_enable = 1'b0;
    logic               load_new_note = 1'b0;
    logic [5:0]         note_to_load = '0;
    logic [5:0]         duration_to_load = '0;
    logic signed [15:0] sample_out;
    logic               out_ready;
    logic               note_done;
    logic               busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lcyc = 0;
    int dn = 0;
    int dcyc = 0;
    int dstrobe = 0;
    int smp[$];
    int scyc[$];

    note_voice dut (
        .clk              (clk),
        .reset            (reset),
        .play_enable      (play_enable),
        .load_new_note    (load_new_note),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .sample_out       (sample_out),
        .out_ready        (out_ready),
        .note_done        (note_done),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and log strobes/note_done.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (out_ready) begin
            smp.push_back(int'(sample_out));
            scyc.push_back(cyc);
        end
        if (note_done) begin
            dn++;
            dcyc = cyc;
            dstrobe = int'(out_ready);
        end
    endtask

    task automatic clear_log();
        smp.delete();
        scyc.delete();
        dn = 0;
        dcyc = 0;
        dstrobe = 0;
    endtask

    task automatic load(input int n, input int d);
        @(negedge clk);
        note_to_load = 6'(n);
        duration_to_load = 6'(d);
        load_new_note = 1'b1;
        step();
        load_new_note = 1'b0;
        lcyc = cyc;
    endtask

    task automatic run_until_done(input int max_cyc);
        for (int i = 0; i < max_cyc && dn == 0; i++) step();
    endtask

    task automatic run_until_strobes(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc && smp.size() < n; i++) step();
    endtask

    function automatic int exp_wave(input int n, input int k);
        logic [21:0] ph;
        ph = 22'(k * (n << 10));
        if (n == 0) return 0;
`ifdef NOTE_VOICE_TRIANGLE_EN
        begin
            logic [15:0] p;
            logic [15:0] u;
            p = ph[20:5];
            u = ph[21] ? ~p : p;
            return int'($signed({~u[15], u[14:0]}));
        end
`else
        return ph[21] ? -32767 : 32767;
`endif
    endfunction

    function automatic int bad_periods(input int from, input int skip_idx, input int skip_len);
        int bad = 0;
        for (int i = from + 1; i < scyc.size(); i++)
            if (scyc[i] - scyc[i-1] != ((i == skip_idx) ? skip_len : 10)) bad++;
        return bad;
    endfunction

    function automatic int bad_waves(input int n);
        int bad = 0;
        for (int i = 0; i < smp.size(); i++)
            if (smp[i] != exp_wave(n, i)) bad++;
        return bad;
    endfunction

    initial begin
        int held;
        int changed;
        int nz;

        // Reset state
        step();
        step();
        chk("rst_sample", int'(sample_out), 0);
        chk("rst_ready", int'(out_ready), 0);
        chk("rst_done", int'(note_done), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        for (int i = 0; i < 100; i++) step();
        chk("idle_no_strobe", smp.size(), 0);

        // Note 57, one beat
        play_enable = 1'b1;
        clear_log();
        load(57, 1);
        chk("t2_busy", int'(busy), 1);
        run_until_done(600);
        chk("t2_first_lat", scyc[0] - lcyc, 9);
        chk("t2_count", smp.size(), 48);
        chk("t2_period", bad_periods(0, -1, 0), 0);
        chk("t2_wave_all", bad_waves(57), 0);
`ifdef NOTE_VOICE_TRIANGLE_EN
        chk("t2_s1", smp[0], -32768);
        begin
            int bad = 0;
            for (int i = 1; i < 36; i++) if (smp[i] <= smp[i-1]) bad++;
            chk("tri_rise", bad, 0);
            bad = 0;
            for (int i = 37; i < 48; i++) if (smp[i] >= smp[i-1]) bad++;
            chk("tri_fall", bad, 0);
        end
`else
        chk("t2_s1", smp[0], 32767);
        chk("t2_s36", smp[35], 32767);
        chk("t2_s37", smp[36], -32767);
        chk("t2_s48", smp[47], -32767);
`endif
        chk("t2_done_cnt", dn, 1);
        chk("t2_done_with_strobe", dstrobe, 1);
        chk("t2_done_cyc", dcyc, scyc[47]);
        step();
        chk("t2_end_busy", int'(busy), 0);
        chk("t2_end_sample", int'(sample_out), 0);

        // Pause 200 cycles right after strobe 36
        clear_log();
        load(57, 1);
        run_until_strobes(36, 600);
        play_enable = 1'b0;
        held = int'(sample_out);
        changed = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (int'(sample_out) != held) changed++;
        end
        chk("t3_pause_strobes", smp.size(), 36);
        chk("t3_pause_hold", changed, 0);
        chk("t3_pause_done", dn, 0);
        play_enable = 1'b1;
        run_until_done(600);
        chk("t3_count", smp.size(), 48);
        chk("t3_wave_all", bad_waves(57), 0);
        chk("t3_period", bad_periods(0, 36, 210), 0);
        chk("t3_done", dn, 1);

        // Retrigger note 1 with note 51 at strobe 5
        clear_log();
        load(1, 8);
        run_until_strobes(5, 100);
        chk("t4_pre_strobes", smp.size(), 5);
        clear_log();
        load(51, 50);
        run_until_strobes(3, 100);
        chk("t4_first_lat", scyc[0] - lcyc, 9);
        chk("t4_phase0", smp[0], exp_wave(51, 0));
        chk("t4_wave_all", bad_waves(51), 0);
        chk("t4_no_done", dn, 0);

        // Duration 0 (also retriggers over note 51)
        clear_log();
        load(5, 0);
        chk("t5_busy_load", int'(busy), 1);
        step();
        chk("t5_done", dn, 1);
        chk("t5_done_cyc", dcyc - lcyc, 1);
        chk("t5_busy", int'(busy), 0);
        for (int i = 0; i < 30; i++) step();
        chk("t5_no_strobe", smp.size(), 0);

        // Rest note, two beats
        clear_log();
        load(0, 2);
        run_until_done(1200);
        nz = 0;
        foreach (smp[i]) if (smp[i] != 0) nz++;
        chk("t6_count", smp.size(), 96);
        chk("t6_silent", nz, 0);
        chk("t6_done", dn, 1);

        // Reset mid-note, with a simultaneous load that must lose
        clear_log();
        load(57, 1);
        run_until_strobes(40, 600);
        @(negedge clk);
        reset = 1'b1;
        load_new_note = 1'b1;
        note_to_load = 6'd57;
        duration_to_load = 6'd3;
        step();
        chk("t7_sample", int'(sample_out), 0);
        chk("t7_ready", int'(out_ready), 0);
        chk("t7_done", int'(note_done), 0);
        chk("t7_busy", int'(busy), 0);
        load_new_note = 1'b0;
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
